// File: rtl/key_dispatch_scheduler.sv
// key_dispatch_scheduler: hands LFSR key candidates to idle cores round-robin, latches a winning key and reports exhaustion
module key_dispatch_scheduler #(
   parameter int NUM_CORES = 4,
   parameter int KEY_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [KEY_WIDTH-1:0] lfsr_key,
   input  logic                 lfsr_available,
   input  logic                 lfsr_finished,
   output logic                 lfsr_read,
   input  logic [NUM_CORES-1:0] core_req,
   output logic [NUM_CORES-1:0] core_grant,
   output logic [KEY_WIDTH-1:0] core_key,
   input  logic [NUM_CORES-1:0] core_done,
   input  logic [NUM_CORES-1:0] core_found,
   output logic                 found,
   output logic [KEY_WIDTH-1:0] found_key,
   output logic                 exhausted,
   output logic                 abort,
   output logic                 busy,
   output logic [KEY_WIDTH-1:0] keys_dispatched
);
   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   typedef enum logic [2:0] {IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED} state_t;
   state_t state, state_nxt;
   logic [NUM_CORES-1:0] outstanding, valid_found, eligible;
   logic [KEY_WIDTH-1:0] key_reg [NUM_CORES];
   logic [PW-1:0] rr_ptr, sel, win, idx;
   logic read_q, any_found, grant_ok, hit;
   assign valid_found = core_done & core_found & outstanding;
   assign any_found = |valid_found;
   // a core retiring its key this cycle may take the next one immediately
   assign eligible = core_req & ~(outstanding & ~core_done);
   assign grant_ok = state == DISPATCH && lfsr_available && !read_q && !any_found && !lfsr_finished && |eligible;
   assign lfsr_read = grant_ok;
   assign core_grant = grant_ok ? (NUM_CORES'(1) << sel) : '0;
   assign core_key = lfsr_key;
   assign found = state == FOUND;
   assign abort = found;
   assign exhausted = state == EXHAUSTED;
   assign busy = state == DISPATCH || state == DRAIN;
   always_comb begin
      sel = rr_ptr;
      hit = 1'b0;
      idx = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = PW'((int'(rr_ptr) + k) % NUM_CORES);
         if (!hit && eligible[idx]) begin
            hit = 1'b1;
            sel = idx;
         end
      end
   end
   always_comb begin
      win = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--)
         if (valid_found[i]) win = PW'(i);
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = DISPATCH;
         DISPATCH: state_nxt = any_found ? FOUND : lfsr_finished ? DRAIN : DISPATCH;
         DRAIN:    state_nxt = any_found ? FOUND : (outstanding == '0) ? EXHAUSTED : DRAIN;
         default:  state_nxt = state;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         read_q <= 1'b0;
         outstanding <= '0;
         rr_ptr <= '0;
         found_key <= '0;
         keys_dispatched <= '0;
      end else begin
         state <= state_nxt;
         read_q <= lfsr_read;
         outstanding <= (outstanding & ~core_done) | core_grant;
         if (grant_ok) begin
            rr_ptr <= PW'((int'(sel) + 1) % NUM_CORES);
            if (~&keys_dispatched) keys_dispatched <= keys_dispatched + KEY_WIDTH'(1);
         end
         if (state_nxt == FOUND && state != FOUND) found_key <= key_reg[win];
      end
   end
   always_ff @(posedge clk)
      for (int i = 0; i < NUM_CORES; i++)
         if (core_grant[i]) key_reg[i] <= lfsr_key;
endmodule
